// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fetch_stage_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: priority reset > bubble insert > hold > load.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            bubble,
  input  logic [XLEN-1:0] bubble_pc,
  input  logic [XLEN-1:0] pc_in,
  input  logic [ILEN-1:0] instr_in,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] instr,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (bubble) begin
      pc    <= bubble_pc;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!hold) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALT/ERR control and IF/ID register.
// Redirects beat stalls; a misaligned redirect locks the stage in ERR until reset.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter logic [XLEN-1:0] IMEM_LIMIT = 64'd168,
  parameter logic [ILEN-1:0] NOP_INSTR  = NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [ILEN-1:0] ifid_instr,
  output logic            ifid_valid,
  output logic            fetch_err,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n, bubble_pc;
  logic            hold, bubble, count_inc;
  logic            target_ok;

  assign target_ok = (branch_target[1:0] == 2'b00);
  assign imem_addr = pc;
  assign fetch_err = (state == ST_ERR);
  assign halted    = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      fetch_count <= 32'd0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (count_inc) fetch_count <= fetch_count + 32'd1;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    hold      = 1'b0;
    bubble    = 1'b0;
    bubble_pc = pc;
    count_inc = 1'b0;
    case (state)
      ST_RUN, ST_HALT: begin
        if (branch_taken) begin
          bubble = 1'b1;
          if (target_ok) begin
            state_n   = ST_RUN;
            pc_n      = branch_target;
            bubble_pc = branch_target;
          end else begin
            state_n = ST_ERR;
          end
        end else if (state == ST_HALT) begin
          bubble = 1'b1;
        end else if (stall) begin
          hold = 1'b1;
        end else if (pc >= IMEM_LIMIT) begin
          // Past the end of instruction memory: park without capturing data.
          state_n = ST_HALT;
          bubble  = 1'b1;
        end else begin
          pc_n      = pc + 64'd4;
          count_inc = 1'b1;
        end
      end
      default: bubble = 1'b1;
    endcase
  end

  ifid_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .bubble   (bubble),
    .bubble_pc(bubble_pc),
    .pc_in    (pc),
    .instr_in (imem_instr),
    .pc       (ifid_pc),
    .instr    (ifid_instr),
    .valid    (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a small instruction memory model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_err;
  logic        halted;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .ifid_valid   (ifid_valid),
    .fetch_err    (fetch_err),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'd0) return 32'h0090_0093;
    if (a == 64'd4) return 32'h0020_0113;
    if (a == 64'd8) return 32'h0070_0193;
    if (a < 64'd256) return 32'h1000_0000 | 32'(a >> 2);
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [63:0] tgt;
    logic [63:0] e_addr;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_err;
    logic        e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] a, input logic [63:0] p,
                         input logic [31:0] i, input logic v, input logic e,
                         input logic h, input logic [31:0] c);
    chk({tag, ".imem_addr"},   imem_addr,   a);
    chk({tag, ".ifid_pc"},     ifid_pc,     p);
    chk({tag, ".ifid_instr"},  64'(ifid_instr), 64'(i));
    chk({tag, ".ifid_valid"},  64'(ifid_valid), 64'(v));
    chk({tag, ".fetch_err"},   64'(fetch_err),  64'(e));
    chk({tag, ".halted"},      64'(halted),     64'(h));
    chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(c));
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [63:0] t);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           rst  stl  br   tgt      addr     ifid_pc  instr         v  err halt cnt
    vecs[0]  = '{1'b1,1'b0,1'b0,64'h0,  64'h0,  64'h0,  32'h0000_0013,1'b0,1'b0,1'b0,32'd0};
    vecs[1]  = '{1'b0,1'b0,1'b0,64'h0,  64'h4,  64'h0,  32'h0090_0093,1'b1,1'b0,1'b0,32'd1};
    vecs[2]  = '{1'b0,1'b0,1'b0,64'h0,  64'h8,  64'h4,  32'h0020_0113,1'b1,1'b0,1'b0,32'd2};
    vecs[3]  = '{1'b0,1'b1,1'b0,64'h0,  64'h8,  64'h4,  32'h0020_0113,1'b1,1'b0,1'b0,32'd2};
    vecs[4]  = '{1'b0,1'b1,1'b0,64'h0,  64'h8,  64'h4,  32'h0020_0113,1'b1,1'b0,1'b0,32'd2};
    vecs[5]  = '{1'b0,1'b1,1'b0,64'h0,  64'h8,  64'h4,  32'h0020_0113,1'b1,1'b0,1'b0,32'd2};
    vecs[6]  = '{1'b0,1'b0,1'b0,64'h0,  64'hC,  64'h8,  32'h0070_0193,1'b1,1'b0,1'b0,32'd3};
    vecs[7]  = '{1'b0,1'b1,1'b1,64'h48, 64'h48, 64'h48, 32'h0000_0013,1'b0,1'b0,1'b0,32'd3};
    vecs[8]  = '{1'b0,1'b0,1'b0,64'h0,  64'h4C, 64'h48, 32'h1000_0012,1'b1,1'b0,1'b0,32'd4};
    vecs[9]  = '{1'b0,1'b0,1'b1,64'h4A, 64'h4C, 64'h4C, 32'h0000_0013,1'b0,1'b1,1'b0,32'd4};
    vecs[10] = '{1'b0,1'b0,1'b1,64'h0,  64'h4C, 64'h4C, 32'h0000_0013,1'b0,1'b1,1'b0,32'd4};
    vecs[11] = '{1'b0,1'b1,1'b0,64'h0,  64'h4C, 64'h4C, 32'h0000_0013,1'b0,1'b1,1'b0,32'd4};
    vecs[12] = '{1'b1,1'b1,1'b1,64'h4A, 64'h0,  64'h0,  32'h0000_0013,1'b0,1'b0,1'b0,32'd0};
    vecs[13] = '{1'b0,1'b0,1'b0,64'h0,  64'h4,  64'h0,  32'h0090_0093,1'b1,1'b0,1'b0,32'd1};

    for (int k = 0; k < 14; k++) begin
      step(vecs[k].rst, vecs[k].stl, vecs[k].br, vecs[k].tgt);
      chk_all($sformatf("vec%0d", k), vecs[k].e_addr, vecs[k].e_pc, vecs[k].e_instr,
              vecs[k].e_valid, vecs[k].e_err, vecs[k].e_halt, vecs[k].e_cnt);
    end

    // Sequential run to the end of memory, then halt and resume by redirect.
    step(1'b1, 1'b0, 1'b0, 64'h0);
    for (int k = 1; k <= 42; k++) begin
      step(1'b0, 1'b0, 1'b0, 64'h0);
      chk($sformatf("run%0d.ifid_pc", k), ifid_pc, 64'(4 * (k - 1)));
      chk($sformatf("run%0d.valid", k), 64'(ifid_valid), 64'd1);
    end
    chk_all("last", 64'd168, 64'd164, mem_word(64'd164), 1'b1, 1'b0, 1'b0, 32'd42);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    chk("halt.halted", 64'(halted), 64'd1);
    chk("halt.valid", 64'(ifid_valid), 64'd0);
    chk("halt.instr", 64'(ifid_instr), 64'h13);
    chk("halt.addr", imem_addr, 64'd168);
    chk("halt.count", 64'(fetch_count), 64'd42);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    chk("halt_stall.halted", 64'(halted), 64'd1);
    chk("halt_stall.valid", 64'(ifid_valid), 64'd0);
    step(1'b0, 1'b0, 1'b1, 64'h4C);
    chk_all("resume", 64'h4C, 64'h4C, 32'h13, 1'b0, 1'b0, 1'b0, 32'd42);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    chk_all("resume2", 64'h50, 64'h4C, mem_word(64'h4C), 1'b1, 1'b0, 1'b0, 32'd43);

    // Misaligned redirect out of HALT goes to ERR and only reset clears it.
    step(1'b1, 1'b0, 1'b0, 64'h0);
    for (int k = 0; k < 43; k++) step(1'b0, 1'b0, 1'b0, 64'h0);
    chk("halt2.halted", 64'(halted), 64'd1);
    step(1'b0, 1'b0, 1'b1, 64'h6);
    chk_all("halt_err", 64'd168, 64'd168, 32'h13, 1'b0, 1'b1, 1'b0, 32'd42);
    step(1'b1, 1'b0, 1'b0, 64'h0);
    chk_all("err_rst", 64'h0, 64'h0, 32'h13, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
